// File: rtl/router_reg_param.sv
// Register stage between the router input FSM and the three output FIFOs.
// Latches the header, forwards beats to dout, parks a beat while the FIFO is full, and checks packets.
module router_reg_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int CHECK_MODE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  error,
    output logic                  len_error
);

    localparam int LW = DATA_WIDTH - ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] header_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] calc_chk;
    logic [DATA_WIDTH-1:0] pkt_chk;
    logic [LW-1:0]         beat_cnt;
    logic                  addr_ok;
    logic                  ld_beat;
    logic                  check_seen;
    logic                  parity_set;
    logic [LW-1:0]         hdr_len;

    // Flow control: pkt_valid high marks a payload beat, pkt_valid low during
    // ld_state marks the check beat; fifo_full is back-pressure that diverts
    // the current beat into hold_reg, replayed to dout in laf_state.
    assign addr_ok    = (data_in[ADDR_WIDTH-1:0] != {ADDR_WIDTH{1'b1}});
    assign ld_beat    = ld_state & pkt_valid & ~full_state;
    assign check_seen = ld_state & ~pkt_valid;
    assign parity_set = (check_seen & ~fifo_full) | (laf_state & low_pkt_valid & ~parity_done);
    assign hdr_len    = header_reg[DATA_WIDTH-1:ADDR_WIDTH];

    function automatic logic [DATA_WIDTH-1:0] chk_op(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        if (CHECK_MODE == 1) r = a + b;
        else                 r = a ^ b;
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            header_reg <= '0;
            hold_reg   <= '0;
            dout       <= '0;
        end else begin
            if (detect_add & pkt_valid & addr_ok) header_reg <= data_in;
            if (ld_state & fifo_full) hold_reg <= data_in;
            if (lfd_state)                  dout <= header_reg;
            else if (ld_state & ~fifo_full) dout <= data_in;
            else if (laf_state)             dout <= hold_reg;
        end
    end

    // The header itself is folded into the check, then every accepted payload beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            calc_chk <= '0;
            beat_cnt <= '0;
            pkt_chk  <= '0;
        end else begin
            if (detect_add) begin
                calc_chk <= '0;
                beat_cnt <= '0;
            end else if (lfd_state) begin
                calc_chk <= chk_op(calc_chk, header_reg);
            end else if (ld_beat) begin
                calc_chk <= chk_op(calc_chk, data_in);
                if (beat_cnt != {LW{1'b1}}) beat_cnt <= beat_cnt + LW'(1);
            end
            if (check_seen) pkt_chk <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            low_pkt_valid <= 1'b0;
            parity_done   <= 1'b0;
            error         <= 1'b0;
            len_error     <= 1'b0;
        end else begin
            if (rst_int_reg)     low_pkt_valid <= 1'b0;
            else if (check_seen) low_pkt_valid <= 1'b1;

            if (detect_add)      parity_done <= 1'b0;
            else if (parity_set) parity_done <= 1'b1;

            // Flags are evaluated the edge after parity_done and stay set until the next header.
            if (detect_add) begin
                error     <= 1'b0;
                len_error <= 1'b0;
            end else if (parity_done) begin
                error     <= error | (calc_chk != pkt_chk);
                len_error <= len_error | (beat_cnt != hdr_len);
            end
        end
    end

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: XOR-mode and sum-mode instances share stimulus;
// dout is scoreboarded against beats queued by the drivers.
module tb_router_reg_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg;
    logic [7:0] dout0, dout1;
    logic       pd0, pd1, lpv0, lpv1, err0, err1, lerr0, lerr1;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [7:0] exp_header;
    logic [7:0] m_chk0, m_chk1;
    logic [5:0] m_cnt;

    always #5 clock = ~clock;

    router_reg_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CHECK_MODE(0)) u_dut0 (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout0), .parity_done(pd0),
        .low_pkt_valid(lpv0), .error(err0), .len_error(lerr0));

    router_reg_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CHECK_MODE(1)) u_dut1 (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout1), .parity_done(pd1),
        .low_pkt_valid(lpv1), .error(err1), .len_error(lerr1));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    task automatic drive_header(input logic [7:0] hdr);
        idle_inputs();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = hdr;
        tick();
        m_chk0 = 8'h00;
        m_chk1 = 8'h00;
        m_cnt  = 6'd0;
        if (hdr[1:0] != 2'b11) exp_header = hdr;
        idle_inputs();
        lfd_state = 1'b1;
        pkt_valid = 1'b1;
        m_chk0 = m_chk0 ^ exp_header;
        m_chk1 = m_chk1 + exp_header;
        exp_q.push_back(exp_header);
        tick();
        obs_q.push_back(dout0);
    endtask

    task automatic drive_payload(input logic [7:0] b, input logic full);
        idle_inputs();
        ld_state  = 1'b1;
        pkt_valid = 1'b1;
        fifo_full = full;
        data_in   = b;
        m_chk0 = m_chk0 ^ b;
        m_chk1 = m_chk1 + b;
        if (m_cnt != 6'h3f) m_cnt = m_cnt + 6'd1;
        if (!full) exp_q.push_back(b);
        tick();
        if (!full) obs_q.push_back(dout0);
    endtask

    task automatic drive_check(input logic [7:0] c, input logic full);
        idle_inputs();
        ld_state  = 1'b1;
        fifo_full = full;
        data_in   = c;
        if (!full) exp_q.push_back(c);
        tick();
        if (!full) obs_q.push_back(dout0);
        idle_inputs();
    endtask

    task automatic end_packet();
        idle_inputs();
        rst_int_reg = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        data_in = 8'h00;
        reset   = 1'b1;
        tick();
        tick();
        n_checks++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout0); end
        n_checks++; if (pd0 !== 1'b0)    begin n_fail++; $display("FAIL reset_parity_done got %b want 0", pd0); end
        n_checks++; if (lpv0 !== 1'b0)   begin n_fail++; $display("FAIL reset_low_pkt_valid got %b want 0", lpv0); end
        n_checks++; if (err0 !== 1'b0)   begin n_fail++; $display("FAIL reset_error got %b want 0", err0); end
        n_checks++; if (lerr0 !== 1'b0)  begin n_fail++; $display("FAIL reset_len_error got %b want 0", lerr0); end
        reset      = 1'b0;
        exp_header = 8'h00;
    endtask

    task automatic test_good_xor();
        logic [7:0] chk;
        exp_q.delete(); obs_q.delete();
        drive_header(8'h22);
        for (int i = 0; i < 8; i++) drive_payload(8'($urandom_range(0, 255)), 1'b0);
        chk = m_chk0;
        drive_check(chk, 1'b0);
        n_checks++; if (pd0 !== 1'b1)  begin n_fail++; $display("FAIL good_parity_done got %b want 1", pd0); end
        n_checks++; if (lpv0 !== 1'b1) begin n_fail++; $display("FAIL good_low_pkt_valid got %b want 1", lpv0); end
        end_packet();
        n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL good_error got %b want 0", err0); end
        n_checks++; if (lerr0 !== 1'b0) begin n_fail++; $display("FAIL good_len_error got %b want 0", lerr0); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL good_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL good_dout got %h want %h", o, e); end
        end
    endtask

    task automatic test_bad_check();
        logic [7:0] chk;
        exp_q.delete(); obs_q.delete();
        drive_header(8'h22);
        for (int i = 0; i < 8; i++) drive_payload(8'($urandom_range(0, 255)), 1'b0);
        chk = ~m_chk0;
        drive_check(chk, 1'b0);
        end_packet();
        n_checks++; if (err0 !== (m_chk0 != chk)) begin n_fail++; $display("FAIL bad_error got %b want 1", err0); end
        tick();
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL bad_error_sticky got %b want 1", err0); end
        idle_inputs();
        detect_add = 1'b1;
        data_in    = 8'h23;
        tick();
        idle_inputs();
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL bad_error_clear got %b want 0", err0); end
    endtask

    task automatic test_sum_mode();
        logic [7:0] chks[2];
        chks[0] = 8'h1F;
        chks[1] = 8'h1E;
        for (int k = 0; k < 2; k++) begin
            drive_header(8'h0E);
            drive_payload(8'hF0, 1'b0);
            drive_payload(8'h20, 1'b0);
            drive_payload(8'h01, 1'b0);
            drive_check(chks[k], 1'b0);
            end_packet();
            n_checks++; if (err1 !== (m_chk1 != chks[k])) begin n_fail++; $display("FAIL sum_error chk %h got %b want %b", chks[k], err1, (m_chk1 != chks[k])); end
            n_checks++; if (lerr1 !== 1'b0) begin n_fail++; $display("FAIL sum_len_error got %b want 0", lerr1); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_len_mismatch();
        exp_q.delete(); obs_q.delete();
        drive_header(8'h22);
        for (int i = 0; i < 6; i++) drive_payload(8'($urandom_range(0, 255)), 1'b0);
        drive_check(m_chk0, 1'b0);
        end_packet();
        n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL len_error_flag_err got %b want 0", err0); end
        n_checks++; if (lerr0 !== (m_cnt != exp_header[7:2])) begin n_fail++; $display("FAIL len_mismatch got %b want 1", lerr0); end
    endtask

    task automatic test_fifo_stall();
        logic [7:0] last;
        exp_q.delete(); obs_q.delete();
        drive_header(8'h22);
        last = 8'h00;
        for (int i = 0; i < 3; i++) begin
            last = 8'($urandom_range(0, 255));
            drive_payload(last, 1'b0);
        end
        drive_payload(8'hA5, 1'b1);
        n_checks++; if (dout0 !== last) begin n_fail++; $display("FAIL stall_hold_ld got %h want %h", dout0, last); end
        idle_inputs();
        full_state = 1'b1;
        fifo_full  = 1'b1;
        tick();
        n_checks++; if (dout0 !== last) begin n_fail++; $display("FAIL stall_hold_full got %h want %h", dout0, last); end
        idle_inputs();
        laf_state = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        obs_q.push_back(dout0);
        for (int i = 0; i < 4; i++) drive_payload(8'($urandom_range(0, 255)), 1'b0);
        drive_check(m_chk0, 1'b0);
        end_packet();
        n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL stall_error got %b want 0", err0); end
        n_checks++; if (lerr0 !== 1'b0) begin n_fail++; $display("FAIL stall_len_error got %b want 0", lerr0); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL stall_dout got %h want %h", o, e); end
        end
    endtask

    task automatic test_invalid_addr();
        exp_q.delete(); obs_q.delete();
        drive_header(8'h23);
        drive_check(m_chk0, 1'b0);
        end_packet();
        n_checks++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL inv_sb_count got %0d want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL inv_dout got %h want %h", o, e); end
        end
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL inv_error got %b want 0", err0); end
        n_checks++; if (lerr0 !== (m_cnt != exp_header[7:2])) begin n_fail++; $display("FAIL inv_len_error got %b want 1", lerr0); end
    endtask

    task automatic test_zero_len();
        drive_header(8'h02);
        drive_check(m_chk0, 1'b0);
        end_packet();
        n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL zero_error got %b want 0", err0); end
        n_checks++; if (lerr0 !== 1'b0) begin n_fail++; $display("FAIL zero_len_error got %b want 0", lerr0); end
    endtask

    task automatic test_full_check_beat();
        logic [7:0] chk;
        drive_header(8'h0A);
        drive_payload(8'($urandom_range(0, 255)), 1'b0);
        drive_payload(8'($urandom_range(0, 255)), 1'b0);
        chk = m_chk0;
        drive_check(chk, 1'b1);
        n_checks++; if (pd0 !== 1'b0)  begin n_fail++; $display("FAIL fullchk_pd_early got %b want 0", pd0); end
        n_checks++; if (lpv0 !== 1'b1) begin n_fail++; $display("FAIL fullchk_low got %b want 1", lpv0); end
        full_state = 1'b1;
        fifo_full  = 1'b1;
        tick();
        idle_inputs();
        laf_state = 1'b1;
        tick();
        n_checks++; if (pd0 !== 1'b1)  begin n_fail++; $display("FAIL fullchk_pd got %b want 1", pd0); end
        n_checks++; if (dout0 !== chk) begin n_fail++; $display("FAIL fullchk_dout got %h want %h", dout0, chk); end
        end_packet();
        n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL fullchk_error got %b want 0", err0); end
        n_checks++; if (lerr0 !== 1'b0) begin n_fail++; $display("FAIL fullchk_len_error got %b want 0", lerr0); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_rst_int_wins();
        drive_header(8'h0A);
        drive_payload(8'($urandom_range(0, 255)), 1'b0);
        drive_payload(8'($urandom_range(0, 255)), 1'b0);
        idle_inputs();
        ld_state    = 1'b1;
        rst_int_reg = 1'b1;
        data_in     = m_chk0;
        tick();
        idle_inputs();
        n_checks++; if (lpv0 !== 1'b0) begin n_fail++; $display("FAIL rst_int_low got %b want 0", lpv0); end
        n_checks++; if (pd0 !== 1'b1)  begin n_fail++; $display("FAIL rst_int_pd got %b want 1", pd0); end
        tick();
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        drive_header(8'h22);
        for (int i = 0; i < 3; i++) drive_payload(8'($urandom_range(1, 255)), 1'b0);
        ld_state  = 1'b1;
        pkt_valid = 1'b1;
        data_in   = 8'h5A;
        reset     = 1'b1;
        tick();
        n_checks++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL mid_reset_dout got %h want 00", dout0); end
        n_checks++; if (pd0 !== 1'b0)    begin n_fail++; $display("FAIL mid_reset_pd got %b want 0", pd0); end
        n_checks++; if (lpv0 !== 1'b0)   begin n_fail++; $display("FAIL mid_reset_low got %b want 0", lpv0); end
        n_checks++; if (err0 !== 1'b0)   begin n_fail++; $display("FAIL mid_reset_error got %b want 0", err0); end
        n_checks++; if (lerr0 !== 1'b0)  begin n_fail++; $display("FAIL mid_reset_len_error got %b want 0", lerr0); end
        n_checks++; if (dout1 !== 8'h00) begin n_fail++; $display("FAIL mid_reset_dout1 got %h want 00", dout1); end
        reset = 1'b0;
        idle_inputs();
        exp_header = 8'h00;
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 8'h00;
        idle_inputs();
        test_reset();
        test_good_xor();
        test_bad_check();
        test_sum_mode();
        test_len_mismatch();
        test_fifo_stall();
        test_invalid_addr();
        test_zero_len();
        test_full_check_beat();
        test_rst_int_wins();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
